// File: rtl/get_legendre_segment_barrel_sdiv_pkg.sv
// Shared definitions for the barrel Legendre segment signed divider.
//
// Contents:
//   - default operand/result widths (31-bit signed dividend, 13-bit unsigned
//     divisor, 18-bit signed quotient, 14-bit signed remainder)
//   - FSM state encoding
//   - packed result record registered at the end of an operation
//
// Optional feature macro: GET_LEGENDRE_SEGMENT_BARREL_SDIV_REM_EN
// (controls whether the remainder is produced; see blk_3daf29).
package get_legendre_segment_barrel_sdiv_pkg;

    localparam int SDIV_DIVIDEND_W = 31;
    localparam int SDIV_DIVISOR_W  = 13;
    localparam int SDIV_QUOTIENT_W = 18;
    localparam int SDIV_REM_W      = SDIV_DIVISOR_W + 1;

    // Saturation bounds of the signed quotient.
    localparam logic signed [SDIV_QUOTIENT_W-1:0] QMAX =
        {1'b0, {(SDIV_QUOTIENT_W-1){1'b1}}};
    localparam logic signed [SDIV_QUOTIENT_W-1:0] QMIN =
        {1'b1, {(SDIV_QUOTIENT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic signed [SDIV_QUOTIENT_W-1:0] quotient;
        logic signed [SDIV_REM_W-1:0]      remainder;
        logic                              ovf;
        logic                              dbz;
    } result_t;

endpackage

// File: rtl/get_legendre_segment_barrel_sdiv_step.sv
// One combinational restoring-division step.
//
// Ports:
//   partial     in   DIVISOR_W  current partial remainder (always < divisor)
//   in_bit      in   1          next dividend-magnitude bit, MSB first
//   divisor     in   DIVISOR_W  unsigned divisor
//   new_partial out  DIVISOR_W  partial remainder after this step
//   q_bit       out  1          quotient bit produced by this step
module get_legendre_segment_barrel_sdiv_step #(
    parameter int DIVISOR_W = 13
) (
    input  logic [DIVISOR_W-1:0] partial,
    input  logic                 in_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] new_partial,
    output logic                 q_bit
);

    logic [DIVISOR_W:0]   shifted;
    logic [DIVISOR_W-1:0] diff;

    always_comb begin
        shifted = {partial, in_bit};
        q_bit   = (shifted >= {1'b0, divisor});
        // When the subtraction happens the result is below the divisor, so the
        // dropped top bit of the shifted value is always zero in the difference.
        diff        = shifted[DIVISOR_W-1:0] - divisor;
        new_partial = q_bit ? diff : shifted[DIVISOR_W-1:0];
    end

endmodule

// File: rtl/blk_3daf29.sv
// Sequential signed divider: 31-bit signed dividend / 13-bit unsigned divisor
// -> 18-bit signed saturated quotient (truncated toward zero) and 14-bit signed
// remainder whose sign follows the dividend. One quotient bit per cycle,
// fixed latency regardless of operands (divide-by-zero included).
//
// Ports:
//   ap_clk     in   1             clock
//   ap_rst     in   1             synchronous active-high reset
//   in_valid   in   1             operand valid
//   in_ready   out  1             idle and out of reset
//   dividend   in   DIVIDEND_W    signed numerator
//   divisor    in   DIVISOR_W     unsigned denominator
//   out_valid  out  1             result valid (held until out_ready)
//   out_ready  in   1             consumer accepts result
//   quotient   out  QUOTIENT_W    signed, truncated toward zero, saturated
//   remainder  out  DIVISOR_W+1   signed, sign of dividend
//   ovf        out  1             quotient was clamped
//   dbz        out  1             divisor was zero
//
// Optional feature macro: GET_LEGENDRE_SEGMENT_BARREL_SDIV_REM_EN
//   defined   -> remainder computed and registered
//   undefined -> remainder is constant 0; quotient, flags and timing unchanged
//
// The result record type is sized from the package widths, so the parameters
// are expected to stay at their package defaults.
module blk_3daf29
    import get_legendre_segment_barrel_sdiv_pkg::*;
#(
    parameter int DIVIDEND_W = SDIV_DIVIDEND_W,
    parameter int DIVISOR_W  = SDIV_DIVISOR_W,
    parameter int QUOTIENT_W = SDIV_QUOTIENT_W
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIVIDEND_W-1:0] dividend,
    input  logic        [DIVISOR_W-1:0]  divisor,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [QUOTIENT_W-1:0] quotient,
    output logic signed [DIVISOR_W:0]    remainder,
    output logic                         ovf,
    output logic                         dbz
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    // Largest quotient magnitudes representable for each sign.
    localparam logic [DIVIDEND_W-1:0] POS_LIM = DIVIDEND_W'((1 << (QUOTIENT_W-1)) - 1);
    localparam logic [DIVIDEND_W-1:0] NEG_LIM = DIVIDEND_W'(1 << (QUOTIENT_W-1));

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg;
    // Holds the dividend magnitude at first; quotient bits shift in from the
    // bottom as magnitude bits leave the top, so after DIVIDEND_W steps it
    // holds the unsigned quotient magnitude.
    logic [DIVIDEND_W-1:0] mag_reg;
    logic [DIVISOR_W-1:0]  partial_reg;
    logic [DIVISOR_W-1:0]  divisor_reg;
    logic                  neg_reg;
    result_t               result_reg;
    result_t               fix_next;

    logic [DIVISOR_W-1:0]  step_partial;
    logic                  step_qbit;
    logic [DIVIDEND_W-1:0] dividend_mag;

    get_legendre_segment_barrel_sdiv_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .partial     (partial_reg),
        .in_bit      (mag_reg[DIVIDEND_W-1]),
        .divisor     (divisor_reg),
        .new_partial (step_partial),
        .q_bit       (step_qbit)
    );

    // -2^(W-1) negates to itself, which read as unsigned is exactly 2^(W-1).
    assign dividend_mag = dividend[DIVIDEND_W-1] ? DIVIDEND_W'(-dividend)
                                                 : DIVIDEND_W'(dividend);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = CALC;
            CALC:    if (cnt_reg == '0) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sign application, saturation and flags
    // ------------------------------------------------------------------
    always_comb begin
        logic div_zero;
        logic ovf_pos;
        logic ovf_neg;

        fix_next = '0;
        div_zero = (divisor_reg == '0);
        ovf_pos  = !neg_reg && (mag_reg > POS_LIM);
        ovf_neg  =  neg_reg && (mag_reg > NEG_LIM);

        if (div_zero) begin
            fix_next.dbz      = 1'b1;
            fix_next.quotient = neg_reg ? QMIN : QMAX;
        end else begin
            fix_next.ovf = ovf_pos | ovf_neg;
            if (neg_reg) begin
                // A magnitude of exactly 2^(Q-1) negates to QMIN in Q bits.
                fix_next.quotient = ovf_neg ? QMIN
                                            : QUOTIENT_W'(-mag_reg[QUOTIENT_W-1:0]);
            end else begin
                fix_next.quotient = ovf_pos ? QMAX
                                            : QUOTIENT_W'(mag_reg[QUOTIENT_W-1:0]);
            end
`ifdef GET_LEGENDRE_SEGMENT_BARREL_SDIV_REM_EN
            fix_next.remainder = neg_reg ? -$signed({1'b0, partial_reg})
                                         :  $signed({1'b0, partial_reg});
`endif
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            mag_reg     <= '0;
            partial_reg <= '0;
            divisor_reg <= '0;
            neg_reg     <= 1'b0;
            result_reg  <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        mag_reg     <= dividend_mag;
                        neg_reg     <= dividend[DIVIDEND_W-1];
                        divisor_reg <= divisor;
                        partial_reg <= '0;
                        cnt_reg     <= CNT_W'(DIVIDEND_W-1);
                    end
                end
                CALC: begin
                    mag_reg     <= {mag_reg[DIVIDEND_W-2:0], step_qbit};
                    partial_reg <= step_partial;
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                FIX: begin
                    result_reg <= fix_next;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = (state_reg == IDLE) && !ap_rst;
    assign out_valid = (state_reg == DONE);
    assign quotient  = result_reg.quotient;
    // Constant zero when the remainder feature is compiled out.
    assign remainder = result_reg.remainder;
    assign ovf       = result_reg.ovf;
    assign dbz       = result_reg.dbz;

endmodule
